sample_stream_ctrl: RTL and testbench
=====================================

# sample_stream_ctrl

Sequencing controller between the SD SPI file reader's byte stream (`outen`/`outbyte`) and the downstream sample datapath (accumulator, display, UART). On a start command it arms on `file_found` and packs file bytes into WORD_BYTES-wide little-endian words. It buffers the words in a show-ahead FIFO, presents them on a valid/ready interface, and detects end of file by an idle timeout. It then flushes any partial word and reports completion, overflow and word count.

## Interface
- WORD_BYTES, 3: bytes per output word (1..4).
- FIFO_DEPTH, 16: word FIFO depth; power of two, ≥2.
- IDLE_TIMEOUT, 1000000: clk cycles without `in_en` in CAPTURE that mark end of file (≥2).

- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle capture command
- file_found  in  1  level from the file reader; 1 = target file located
- in_en  in  1  byte strobe from the file reader
- in_byte  in  8  file byte, valid when in_en=1
- out_valid  out  1  FIFO head word valid
- out_ready  in  1  consumer accepts the head word
- out_data  out  8*WORD_BYTES  FIFO head word
- busy  out  1  state is WAIT_FILE, CAPTURE or FLUSH
- done  out  1  state is DONE
- overflow  out  1  sticky: at least one word dropped
- padded  out  1  sticky: the last word was zero-padded
- word_count  out  32  words accepted into the FIFO since the last start

## Operation
- States: IDLE, WAIT_FILE, CAPTURE, FLUSH, DONE.
- IDLE: `in_en` is ignored. `start` moves to WAIT_FILE and clears the FIFO, byte index, word_count, overflow and padded.
- WAIT_FILE: bytes are dropped. `file_found`=1 moves to CAPTURE on the next cycle and clears the idle counter.
- CAPTURE:
  - Each `in_en` writes `in_byte` into lane `idx` (bits [8*idx+7:8*idx]; first byte is the LSB) and clears the idle counter.
  - When idx=WORD_BYTES-1, the completed word, including the current byte, is pushed and idx returns to 0.
  - Otherwise the idle counter increments. When it reaches IDLE_TIMEOUT-1, the block moves to FLUSH.
- FLUSH:
  - Entry cycle: if idx≠0, push the assembled lanes with the unfilled lanes at 0, set padded, and clear idx.
  - Remain in FLUSH until the FIFO is empty, then go to DONE.
  - Any `in_en` during FLUSH is dropped.
- DONE: `start` restarts, same as from IDLE. `file_found` is ignored.
- `start` in WAIT_FILE, CAPTURE or FLUSH is ignored.
- Push rule: a push succeeds if the FIFO is not full, or if a pop occurs in the same cycle. A successful push increments word_count, saturating at 2^32-1. A failed push discards the word and sets overflow.
- Pop occurs when out_valid & out_ready. out_data holds steady while out_valid=1 and out_ready=0.
- The FIFO is the only storage on the output side. Clearing on `start` empties it, and any unread words are discarded.

## Timing
- Reset values:
  - state IDLE
  - out_valid=0, out_data=0, busy=0, done=0
  - overflow=0, padded=0, word_count=0
  - idx, idle counter and FIFO pointers all 0.
- `start` at cycle N: busy=1 from cycle N+1.
- WAIT_FILE→CAPTURE: transition takes one cycle after `file_found` is sampled high. A byte in that same cycle is dropped.
- A completing byte at cycle N with the FIFO empty gives out_valid=1 and the new out_data in cycle N+1. word_count updates in N+1.
- A pop at cycle N shows the next word, or out_valid=0, in N+1.
- Timeout: with the last byte at cycle N, FLUSH is entered at cycle N+IDLE_TIMEOUT. The padded word is visible at N+IDLE_TIMEOUT+1 if the FIFO was empty.
- DONE is asserted the cycle after FLUSH observes the FIFO empty.
- In_en arrives once per SPI byte time (≥800 cycles apart). Back-to-back in_en on every cycle must still be handled without loss apart from FIFO full.
- rst asserted in any state, including mid-word or mid-FIFO, returns all outputs to reset values immediately. No partial word is retained.

## Test plan
- start, file_found=1, bytes 0x11..0x16, out_ready=1 → words 0x331211? No: words 0x131211 and 0x161514. After timeout: done=1, word_count=2, padded=0, overflow=0.
- start, bytes 0xA1..0xA7 → words 0xA3A2A1 and 0xA6A5A4, then 0x0000A7 after the timeout. padded=1, word_count=3.
- out_ready=0, 17 full words (FIFO_DEPTH=16) → out_valid=1, word_count=16, overflow=1. Then raise out_ready: exactly the first 16 words are read in order, then done=1.
- file_found=0 while 3 bytes arrive, then file_found=1 and 3 bytes 0x01,0x02,0x03 → only 0x030201 is output. A start pulse during CAPTURE has no effect.
- rst pulse after 2 bytes of a word and 5 words queued → the next cycle shows out_valid=0, word_count=0, state IDLE. A fresh start plus 3 bytes yields a single correct word.
- FIFO full with out_ready=1 and a word completing in the same cycle → push accepted, overflow stays 0, count stays at 16 entries.

Source files
------------

// File: rtl/sample_stream_if.sv
// Byte-in / word-out stream bundle for sample_stream_ctrl.
// The controller is the slave; the reader/consumer side is the master.
interface sample_stream_if #(
    parameter int WORD_BYTES = 3
);
    logic                      start;
    logic                      file_found;
    logic                      in_en;
    logic [7:0]                in_byte;
    logic                      out_valid;
    logic                      out_ready;
    logic [8*WORD_BYTES-1:0]   out_data;
    logic                      busy;
    logic                      done;
    logic                      overflow;
    logic                      padded;
    logic [31:0]               word_count;

    modport slave (
        input  start, file_found, in_en, in_byte, out_ready,
        output out_valid, out_data, busy, done, overflow, padded, word_count
    );

    modport master (
        output start, file_found, in_en, in_byte, out_ready,
        input  out_valid, out_data, busy, done, overflow, padded, word_count
    );
endinterface

// File: rtl/sample_stream_ctrl.sv
// Packs file reader bytes into little-endian words, queues them in a
// show-ahead FIFO and detects end of file by an idle timeout.
module sample_stream_ctrl #(
    parameter int WORD_BYTES   = 3,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    sample_stream_if.slave   s
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam int XW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILE,
        CAPTURE,
        FLUSH,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   idx_q, idx_d;
    logic [W-1:0]    lanes_q, lanes_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [31:0]     wc_q, wc_d;
    logic            ovf_q, ovf_d;
    logic            pad_q, pad_d;

    logic [W-1:0]    mem [FIFO_DEPTH];

    logic            clear;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            empty;
    logic            full;
    logic [W-1:0]    push_word;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && s.out_ready;

    assign s.out_valid  = !empty;
    assign s.out_data   = empty ? '0 : mem[rd_q];
    assign s.busy       = (state_q == WAIT_FILE) || (state_q == CAPTURE) ||
                          (state_q == FLUSH);
    assign s.done       = (state_q == DONE);
    assign s.overflow   = ovf_q;
    assign s.padded     = pad_q;
    assign s.word_count = wc_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lanes_d   = lanes_q;
        idle_d    = idle_q;
        pad_d     = pad_q;
        clear     = 1'b0;
        push_req  = 1'b0;
        push_word = lanes_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (s.start) begin
                    state_d = WAIT_FILE;
                    clear   = 1'b1;
                    idx_d   = '0;
                    lanes_d = '0;
                    pad_d   = 1'b0;
                end
            end
            WAIT_FILE: begin
                if (s.file_found) begin
                    state_d = CAPTURE;
                    idle_d  = '0;
                end
            end
            CAPTURE: begin
                if (s.in_en) begin
                    idle_d = '0;
                    push_word[8*idx_q +: 8] = s.in_byte;
                    if (idx_q == XW'(WORD_BYTES - 1)) begin
                        push_req = 1'b1;
                        idx_d    = '0;
                        lanes_d  = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        lanes_d = push_word;
                    end
                end else if (idle_q == IW'(IDLE_TIMEOUT - 2)) begin
                    // counter is about to reach IDLE_TIMEOUT-1
                    state_d = FLUSH;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            FLUSH: begin
                // lanes above idx are already zero, so lanes_q is the padded word
                if (idx_q != '0) begin
                    push_req = 1'b1;
                    pad_d    = 1'b1;
                    idx_d    = '0;
                    lanes_d  = '0;
                end else if (empty) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_ok = push_req && (!full || pop);
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop);
        cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        ovf_d   = ovf_q | (push_req & ~push_ok);
        wc_d    = (push_ok && (wc_q != '1)) ? wc_q + 1'b1 : wc_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            wc_d  = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lanes_q <= '0;
            idle_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            idle_q  <= idle_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
            pad_q   <= pad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q] <= push_word;
        end
    end
endmodule

// File: tb/tb_sample_stream_ctrl.sv
// Randomized bench for sample_stream_ctrl with a byte-list word model.
// Popped words are collected by a monitor and compared per scenario.
module tb_sample_stream_ctrl;
    localparam int WB    = 3;
    localparam int DEPTH = 16;
    localparam int TO    = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_stream_if #(.WORD_BYTES(WB)) ifc ();

    sample_stream_ctrl #(
        .WORD_BYTES  (WB),
        .FIFO_DEPTH  (DEPTH),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s  (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] got[$];
    logic [23:0] exp_q[$];
    logic [7:0]  sent[$];
    bit          exp_pad;

    bit   rnd_mode  = 1'b0;
    logic fix_ready = 1'b0;
    logic rnd_ready = 1'b0;
    assign ifc.out_ready = rnd_mode ? rnd_ready : fix_ready;

    always @(negedge clk) rnd_ready <= 1'($urandom_range(0, 1));

    always @(posedge clk)
        if (!rst && ifc.out_valid && ifc.out_ready)
            got.push_back(ifc.out_data);

    // expected words straight from the byte list: byte i lands in lane i%WB
    function automatic void build_exp();
        logic [23:0] w;
        exp_q.delete();
        exp_pad = 1'b0;
        w = '0;
        for (int i = 0; i < sent.size(); i++) begin
            w = w | (24'(sent[i]) << (8 * (i % WB)));
            if (i % WB == WB - 1) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
        if (sent.size() % WB != 0) begin
            exp_q.push_back(w);
            exp_pad = 1'b1;
        end
    endfunction

    task automatic start_capture(input bit settle);
        @(negedge clk) ifc.start = 1'b1;
        @(negedge clk) ifc.start = 1'b0;
        if (settle) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit keep);
        @(negedge clk);
        ifc.in_en   = 1'b1;
        ifc.in_byte = b;
        if (keep) sent.push_back(b);
        if (gap > 0) begin
            @(negedge clk) ifc.in_en = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic stop_en();
        @(negedge clk) ifc.in_en = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ifc.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h want 0/0", ifc.out_valid, ifc.out_data);
        end
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b want 0/0", ifc.busy, ifc.done);
        end
        checks++;
        if (ifc.overflow !== 1'b0 || ifc.padded !== 1'b0 || ifc.word_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_status got ovf=%b pad=%b wc=%0d want 0/0/0",
                     ifc.overflow, ifc.padded, ifc.word_count);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b v=%b want 0/0", ifc.busy, ifc.out_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        got.delete();
        sent.delete();
        fix_ready = 1'b1;
        ifc.file_found = 1'b1;
        start_capture(1'b0);
        checks++;
        if (ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", ifc.busy);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), 3, 1'b1);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got timeout want done");
        end
        checks++;
        if (got.size() !== 2 || got[0] !== 24'h131211 || got[1] !== 24'h161514) begin
            errors++;
            $display("FAIL basic_words got n=%0d w0=%h want 2 131211 161514",
                     got.size(), got.size() > 0 ? got[0] : 24'hx);
        end
        checks++;
        if (ifc.word_count !== 32'd2 || ifc.padded !== 1'b0 || ifc.overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got wc=%0d pad=%b ovf=%b want 2/0/0",
                     ifc.word_count, ifc.padded, ifc.overflow);
        end
    endtask

    task automatic test_padded();
        bit ok;
        got.delete();
        sent.delete();
        start_capture(1'b1);
        for (int i = 0; i < 7; i++) send(8'hA1 + 8'(i), 1, 1'b1);
        wait_done(ok);
        build_exp();
        checks++;
        if (!ok || got.size() !== 3) begin
            errors++;
            $display("FAIL pad_count got ok=%b n=%0d want 1 3", ok, got.size());
        end
        checks++;
        if (got.size() == 3 && got[2] !== 24'h0000A7) begin
            errors++;
            $display("FAIL pad_word got %h want 0000a7", got[2]);
        end
        checks++;
        if (ifc.padded !== 1'b1 || ifc.word_count !== 32'd3 || exp_pad !== 1'b1) begin
            errors++;
            $display("FAIL pad_status got pad=%b wc=%0d want 1/3", ifc.padded, ifc.word_count);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int r = 0; r < 4; r++) begin
            got.delete();
            sent.delete();
            rnd_mode = 1'b1;
            start_capture(1'b1);
            n = $urandom_range(1, 27);
            for (int i = 0; i < n; i++)
                send(8'($urandom), ($urandom_range(0, 3) == 0) ? 30 : $urandom_range(0, 3), 1'b1);
            stop_en();
            wait_done(ok);
            build_exp();
            checks++;
            if (!ok || got.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rnd_count got ok=%b n=%0d want %0d", ok, got.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd_word[%0d] got %h want %h", i, got[i], exp_q[i]);
                end
            end
            checks++;
            if (ifc.word_count !== 32'(exp_q.size()) || ifc.padded !== exp_pad ||
                ifc.overflow !== 1'b0) begin
                errors++;
                $display("FAIL rnd_status got wc=%0d pad=%b ovf=%b want %0d/%b/0",
                         ifc.word_count, ifc.padded, ifc.overflow, exp_q.size(), exp_pad);
            end
        end
        rnd_mode = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        got.delete();
        sent.delete();
        fix_ready = 1'b0;
        start_capture(1'b1);
        for (int i = 0; i < 17 * WB; i++) send(8'($urandom), 0, 1'b1);
        stop_en();
        @(negedge clk);
        build_exp();
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.word_count !== 32'd16 || ifc.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_status got v=%b wc=%0d ovf=%b want 1/16/1",
                     ifc.out_valid, ifc.word_count, ifc.overflow);
        end
        checks++;
        if (ifc.out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL ovf_head got %h want %h", ifc.out_data, exp_q[0]);
        end
        fix_ready = 1'b1;
        wait_done(ok);
        checks++;
        if (!ok || got.size() !== 16) begin
            errors++;
            $display("FAIL ovf_drain got ok=%b n=%0d want 1 16", ok, got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_file_found();
        bit ok;
        got.delete();
        sent.delete();
        fix_ready = 1'b1;
        ifc.file_found = 1'b0;
        start_capture(1'b0);
        for (int i = 0; i < 3; i++) send(8'hE1 + 8'(i), 2, 1'b0);
        checks++;
        if (ifc.busy !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_file got busy=%b v=%b want 1/0", ifc.busy, ifc.out_valid);
        end
        @(negedge clk) ifc.file_found = 1'b1;
        @(negedge clk);
        send(8'h01, 1, 1'b1);
        start_capture(1'b0);
        send(8'h02, 1, 1'b1);
        send(8'h03, 1, 1'b1);
        wait_done(ok);
        checks++;
        if (!ok || got.size() !== 1 || got[0] !== 24'h030201) begin
            errors++;
            $display("FAIL ff_words got ok=%b n=%0d w0=%h want 1 1 030201",
                     ok, got.size(), got.size() > 0 ? got[0] : 24'hx);
        end
        checks++;
        if (ifc.word_count !== 32'd1) begin
            errors++;
            $display("FAIL ff_count got %0d want 1", ifc.word_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        got.delete();
        sent.delete();
        fix_ready = 1'b0;
        start_capture(1'b1);
        for (int i = 0; i < 5 * WB + 2; i++) send(8'($urandom), 0, 1'b1);
        stop_en();
        checks++;
        if (ifc.word_count !== 32'd5) begin
            errors++;
            $display("FAIL pre_rst_count got %0d want 5", ifc.word_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.word_count !== 32'd0 || ifc.busy !== 1'b0 ||
            ifc.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got v=%b wc=%0d busy=%b done=%b want 0/0/0/0",
                     ifc.out_valid, ifc.word_count, ifc.busy, ifc.done);
        end
        @(negedge clk) rst = 1'b0;
        got.delete();
        sent.delete();
        fix_ready = 1'b1;
        start_capture(1'b1);
        for (int i = 0; i < 3; i++) send(8'($urandom), 2, 1'b1);
        wait_done(ok);
        build_exp();
        checks++;
        if (!ok || got.size() !== 1 || got[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL post_rst_word got ok=%b n=%0d w0=%h want 1 1 %h",
                     ok, got.size(), got.size() > 0 ? got[0] : 24'hx, exp_q[0]);
        end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        logic [7:0] b;
        got.delete();
        sent.delete();
        fix_ready = 1'b0;
        start_capture(1'b1);
        for (int i = 0; i < 16 * WB + 2; i++) send(8'($urandom), 0, 1'b1);
        b = 8'($urandom);
        @(negedge clk);
        ifc.in_byte = b;
        fix_ready   = 1'b1;
        sent.push_back(b);
        @(negedge clk);
        ifc.in_en = 1'b0;
        fix_ready = 1'b0;
        checks++;
        if (ifc.overflow !== 1'b0 || ifc.word_count !== 32'd17 || ifc.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop got ovf=%b wc=%0d v=%b want 0/17/1",
                     ifc.overflow, ifc.word_count, ifc.out_valid);
        end
        fix_ready = 1'b1;
        wait_done(ok);
        build_exp();
        checks++;
        if (!ok || got.size() !== 17 || ifc.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got ok=%b n=%0d ovf=%b want 1 17 0",
                     ok, got.size(), ifc.overflow);
        end
        for (int i = 0; i < 17 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_word[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        ifc.start      = 1'b0;
        ifc.file_found = 1'b0;
        ifc.in_en      = 1'b0;
        ifc.in_byte    = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_padded();
        test_random();
        test_overflow();
        test_file_found();
        test_reset_mid();
        test_full_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
